// File: rtl/elevator_pkg.sv
// Shared types and constants for the N-floor elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [1:0] ENG_STOP = 2'b00;
  localparam logic [1:0] ENG_UP   = 2'b01;
  localparam logic [1:0] ENG_DOWN = 2'b10;

  // Width of the floor index; a two-floor car still needs one bit.
  function automatic int unsigned floor_width(input int unsigned floors);
    return (floors > 2) ? $clog2(floors) : 1;
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Cycle counter shared by travel and door dwell timing.
// done flags the last cycle of the interval (count == limit).
module elevator_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  // Clear has priority so every state entry starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Terminal-cycle flag consumed by the controller's next-state logic.
  always_comb begin
    done = (count == limit);
  end

endmodule

// File: rtl/elevator_ctrl_n.sv
// SCAN-policy elevator movement controller for an N-floor car.
// Latches call buttons, times floor-to-floor travel and door dwell,
// and drives registered engine/door outputs.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter  int unsigned FLOORS        = 4,
  parameter  int unsigned TRAVEL_CYCLES = 4,
  parameter  int unsigned DOOR_CYCLES   = 3,
  localparam int unsigned FW            = floor_width(FLOORS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [FLOORS-1:0] interior_panel,
  input  logic [FLOORS-1:0] exterior_panel,
  output logic [1:0]        engine,
  output logic [FLOORS-1:0] doors,
  output logic [FW-1:0]     floor,
  output logic [FLOORS-1:0] pending
);

  localparam int unsigned TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

  state_t            state;
  state_t            nxt_state;
  dir_t              last_dir;
  dir_t              nxt_dir;
  logic [FW-1:0]     nxt_floor;
  logic [FW-1:0]     floor_up;
  logic [FW-1:0]     floor_dn;
  logic [FLOORS-1:0] req_now;
  logic [FLOORS-1:0] clear_mask;
  logic              above;
  logic              below;
  logic              here;
  logic              restart;
  logic              timer_clear;
  logic              timer_done;
  logic [TW-1:0]     timer_limit;
  logic [TW-1:0]     timer_count;

  // Any request strictly above floor f.
  function automatic logic req_above(input logic [FLOORS-1:0] req, input logic [FW-1:0] f);
    logic any;
    any = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (i > 32'(f)) any = any | req[i];
    end
    return any;
  endfunction

  // Any request strictly below floor f.
  function automatic logic req_below(input logic [FLOORS-1:0] req, input logic [FW-1:0] f);
    logic any;
    any = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (i < 32'(f)) any = any | req[i];
    end
    return any;
  endfunction

  elevator_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .clear  (timer_clear),
    .enable (state != IDLE),
    .limit  (timer_limit),
    .count  (timer_count),
    .done   (timer_done)
  );

  // Request summaries relative to the current floor, all from registered pending.
  always_comb begin
    req_now     = interior_panel | exterior_panel;
    above       = req_above(pending, floor);
    below       = req_below(pending, floor);
    here        = pending[floor];
    floor_up    = floor + 1'b1;
    floor_dn    = floor - 1'b1;
    restart     = (state == DOOR_OPEN) && req_now[floor];
    timer_limit = (state == DOOR_OPEN) ? DOOR_LAST : TRAVEL_LAST;
  end

  // SCAN next-state decision; arrival and door-close choices happen on the timer's last cycle.
  always_comb begin
    nxt_state = state;
    nxt_floor = floor;
    nxt_dir   = last_dir;
    unique case (state)
      IDLE: begin
        if (here) begin
          nxt_state = DOOR_OPEN;
        end else if (above && below) begin
          nxt_state = (last_dir == DIR_UP) ? MOVE_UP : MOVE_DOWN;
        end else if (above) begin
          nxt_state = MOVE_UP;
          nxt_dir   = DIR_UP;
        end else if (below) begin
          nxt_state = MOVE_DOWN;
          nxt_dir   = DIR_DOWN;
        end
      end
      MOVE_UP: begin
        nxt_dir = DIR_UP;
        if (timer_done) begin
          nxt_floor = floor_up;
          if (pending[floor_up])                nxt_state = DOOR_OPEN;
          else if (req_above(pending, floor_up)) nxt_state = MOVE_UP;
          else                                   nxt_state = IDLE;
        end
      end
      MOVE_DOWN: begin
        nxt_dir = DIR_DOWN;
        if (timer_done) begin
          nxt_floor = floor_dn;
          if (pending[floor_dn])                 nxt_state = DOOR_OPEN;
          else if (req_below(pending, floor_dn)) nxt_state = MOVE_DOWN;
          else                                   nxt_state = IDLE;
        end
      end
      DOOR_OPEN: begin
        // A fresh call for this floor keeps the doors open instead of closing them.
        if (!restart && timer_done) begin
          if (last_dir == DIR_UP) begin
            if (above) begin
              nxt_state = MOVE_UP;
            end else if (below) begin
              nxt_state = MOVE_DOWN;
              nxt_dir   = DIR_DOWN;
            end else begin
              nxt_state = IDLE;
            end
          end else begin
            if (below) begin
              nxt_state = MOVE_DOWN;
            end else if (above) begin
              nxt_state = MOVE_UP;
              nxt_dir   = DIR_UP;
            end else begin
              nxt_state = IDLE;
            end
          end
        end
      end
      default: nxt_state = IDLE;
    endcase

    timer_clear = (nxt_state != state) || (state == IDLE) || restart ||
                  (((state == MOVE_UP) || (state == MOVE_DOWN)) && timer_done);

    clear_mask = '0;
    if (nxt_state == DOOR_OPEN) clear_mask[nxt_floor] = 1'b1;
  end

  // State, position, request latch and Moore outputs registered together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      floor    <= '0;
      last_dir <= DIR_UP;
      pending  <= '0;
      engine   <= ENG_STOP;
      doors    <= '0;
    end else begin
      state    <= nxt_state;
      floor    <= nxt_floor;
      last_dir <= nxt_dir;
      pending  <= (pending | req_now) & ~clear_mask;
      doors    <= clear_mask;
      unique case (nxt_state)
        MOVE_UP:   engine <= ENG_UP;
        MOVE_DOWN: engine <= ENG_DOWN;
        default:   engine <= ENG_STOP;
      endcase
    end
  end

  timer_in_range: assert property (@(posedge CLK) disable iff (RST) timer_count <= timer_limit);
  engine_legal:   assert property (@(posedge CLK) disable iff (RST) engine != 2'b11);

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Self-checking bench for elevator_ctrl_n: directed scenarios plus random calls,
// every cycle compared against a countdown-based behavioural model.
module tb_elevator_ctrl_n;

  localparam int unsigned FLOORS = 4;
  localparam int unsigned TC     = 4;
  localparam int unsigned DC     = 3;
  localparam int unsigned FW     = 2;

  logic              clk;
  logic              rst;
  logic [FLOORS-1:0] interior_panel;
  logic [FLOORS-1:0] exterior_panel;
  logic [1:0]        engine;
  logic [FLOORS-1:0] doors;
  logic [FW-1:0]     floor_o;
  logic [FLOORS-1:0] pending;

  int n_checks;
  int n_pass;

  // Model: phase 0 = parked, 1 = riding, 2 = doors open; dir is +1/-1.
  int m_phase, m_floor, m_dir, m_left, m_pend;
  int stops[$];
  logic [FLOORS-1:0] prev_doors;

  elevator_ctrl_n #(
    .FLOORS        (FLOORS),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .interior_panel (interior_panel),
    .exterior_panel (exterior_panel),
    .engine         (engine),
    .doors          (doors),
    .floor          (floor_o),
    .pending        (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit m_ahead(input int p, input int f, input int d);
    if (d > 0) return (p >> (f + 1)) != 0;
    return (p & ((1 << f) - 1)) != 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_floor = 0; m_dir = 1; m_left = 0; m_pend = 0;
  endtask

  task automatic model_step(input int req);
    int p;
    p = m_pend;
    case (m_phase)
      0: begin
        if ((p >> m_floor) & 1) begin
          m_phase = 2; m_left = DC;
        end else if (m_ahead(p, m_floor, 1) && m_ahead(p, m_floor, -1)) begin
          m_phase = 1; m_left = TC;
        end else if (m_ahead(p, m_floor, 1)) begin
          m_phase = 1; m_left = TC; m_dir = 1;
        end else if (m_ahead(p, m_floor, -1)) begin
          m_phase = 1; m_left = TC; m_dir = -1;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_dir;
          if ((p >> m_floor) & 1) begin m_phase = 2; m_left = DC; end
          else if (m_ahead(p, m_floor, m_dir)) m_left = TC;
          else m_phase = 0;
        end
      end
      default: begin
        if ((req >> m_floor) & 1) begin
          m_left = DC;
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_ahead(p, m_floor, m_dir)) begin
              m_phase = 1; m_left = TC;
            end else if (m_ahead(p, m_floor, -m_dir)) begin
              m_phase = 1; m_left = TC; m_dir = -m_dir;
            end else begin
              m_phase = 0;
            end
          end
        end
      end
    endcase
    m_pend = (p | req) & ((1 << FLOORS) - 1);
    if (m_phase == 2) m_pend = m_pend & ~(1 << m_floor);
  endtask

  task automatic compare_model();
    int exp_eng, exp_doors;
    exp_eng   = (m_phase == 1) ? ((m_dir > 0) ? 1 : 2) : 0;
    exp_doors = (m_phase == 2) ? (1 << m_floor) : 0;
    check_val("engine",  32'(engine),  32'(exp_eng));
    check_val("doors",   32'(doors),   32'(exp_doors));
    check_val("floor",   32'(floor_o), 32'(m_floor));
    check_val("pending", 32'(pending), 32'(m_pend));
  endtask

  // One clock: drive calls, let the edge happen, advance the model, compare.
  task automatic tick(input logic [FLOORS-1:0] ip, input logic [FLOORS-1:0] ep);
    interior_panel = ip;
    exterior_panel = ep;
    @(posedge clk);
    model_step(int'(ip | ep));
    #1;
    compare_model();
    if (doors != '0 && prev_doors == '0) stops.push_back(int'(floor_o));
    prev_doors = doors;
  endtask

  int eng_up_cnt, eng_dn_cnt, door_cnt, guard;

  initial begin
    n_checks = 0; n_pass = 0;
    interior_panel = '0; exterior_panel = '0;
    prev_doors = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_val("rst_engine",  32'(engine),  32'd0);
    check_val("rst_doors",   32'(doors),   32'd0);
    check_val("rst_floor",   32'(floor_o), 32'd0);
    check_val("rst_pending", 32'(pending), 32'd0);

    // Single call to floor 2 from floor 0.
    tick(4'b0100, 4'b0000);
    check_val("t1_pending", 32'(pending), 32'h4);
    eng_up_cnt = 0; door_cnt = 0;
    repeat (20) begin
      tick('0, '0);
      if (engine == 2'b01) eng_up_cnt++;
      if (doors == 4'b0100) door_cnt++;
    end
    check_val("t1_up_cycles",   32'(eng_up_cnt), 32'd8);
    check_val("t1_door_cycles", 32'(door_cnt),   32'd3);
    check_val("t1_final_pend",  32'(pending),    32'd0);
    check_val("t1_final_eng",   32'(engine),     32'd0);

    // Door restart at floor 2: a same-floor call during the first dwell cycle.
    tick(4'b0100, 4'b0000);
    tick('0, '0);
    door_cnt = (doors == 4'b0100) ? 1 : 0;
    tick(4'b0000, 4'b0100);
    if (doors == 4'b0100) door_cnt++;
    check_val("t5_pend2", 32'(pending[2]), 32'd0);
    repeat (8) begin
      tick('0, '0);
      if (doors == 4'b0100) door_cnt++;
    end
    check_val("t5_door_cycles", 32'(door_cnt), 32'd4);

    // Return to floor 0, then a same-floor hall call while parked there.
    tick(4'b0000, 4'b0001);
    repeat (20) tick('0, '0);
    check_val("at_floor0", 32'(floor_o), 32'd0);
    eng_up_cnt = 0; door_cnt = 0;
    tick(4'b0000, 4'b0001);
    repeat (8) begin
      tick('0, '0);
      if (engine != 2'b00) eng_up_cnt++;
      if (doors == 4'b0001) door_cnt++;
    end
    check_val("t2_no_move",    32'(eng_up_cnt), 32'd0);
    check_val("t2_door_cycles", 32'(door_cnt),  32'd3);

    // Call to 3, then 1 and 0 added two cycles into the climb.
    stops.delete();
    tick(4'b1000, 4'b0000);
    guard = 0;
    while (engine != 2'b01 && guard < 5) begin tick('0, '0); guard++; end
    check_val("t3_start", 32'(engine), 32'd1);
    tick('0, '0);
    tick(4'b0011, 4'b0000);
    repeat (80) tick('0, '0);
    check_val("t3_nstops", 32'(stops.size()), 32'd3);
    if (stops.size() == 3) begin
      check_val("t3_stop0", 32'(stops[0]), 32'd1);
      check_val("t3_stop1", 32'(stops[1]), 32'd3);
      check_val("t3_stop2", 32'(stops[2]), 32'd0);
    end

    // Park at 3, then merged interior+exterior call for floor 0.
    tick(4'b1000, 4'b0000);
    repeat (40) tick('0, '0);
    check_val("at_floor3", 32'(floor_o), 32'd3);
    stops.delete();
    eng_dn_cnt = 0;
    tick(4'b0001, 4'b0001);
    repeat (30) begin
      tick('0, '0);
      if (engine == 2'b10) eng_dn_cnt++;
    end
    check_val("t4_down_cycles", 32'(eng_dn_cnt), 32'd12);
    check_val("t4_nstops", 32'(stops.size()), 32'd1);

    // Asynchronous reset while climbing past floor 1.
    tick(4'b0100, 4'b0000);
    guard = 0;
    while (!(engine == 2'b01 && floor_o == 2'd1) && guard < 20) begin tick('0, '0); guard++; end
    check_val("t6_reached", 32'(floor_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("t6_engine",  32'(engine),  32'd0);
    check_val("t6_doors",   32'(doors),   32'd0);
    check_val("t6_floor",   32'(floor_o), 32'd0);
    check_val("t6_pending", 32'(pending), 32'd0);
    #2 rst = 1'b0;
    model_reset();
    prev_doors = '0;

    // Random sparse calls against the model.
    for (int n = 0; n < 400; n++) begin
      logic [FLOORS-1:0] ip, ep;
      ip = ($urandom_range(0, 5) == 0) ? FLOORS'($urandom_range(0, 15)) : '0;
      ep = ($urandom_range(0, 5) == 0) ? FLOORS'($urandom_range(0, 15)) : '0;
      tick(ip, ep);
    end
    repeat (60) tick('0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
